mac_meta_gen: RTL and testbench

Header-side companion to the MAC rewrite stage: sits upstream of it on the 134-bit packet bus, parses each packet's first beat, and generates the 128-bit metadata word the rewrite stage consumes. It also forwards the packet one cycle late, so the metadata lines up with the rewrite stage's internal pipeline. Framing is tracked with a small state machine, and each generated metadata word carries a per-packet sequence number.

---
 rtl/mac_meta_gen_if.sv | 33 +++
 rtl/mac_meta_gen.sv | 126 ++++++++++++
 tb/tb_mac_meta_gen.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mac_meta_gen_if.sv
// Packet bus, metadata and status signals shared by mac_meta_gen and its neighbours.
// MAC_META_STATS_EN adds the packet/error counter outputs.
interface mac_meta_gen_if;
    logic         i_pkt_valid;
    logic [133:0] i_pkt;
    logic         o_pkt_valid;
    logic [133:0] o_pkt;
    logic         o_meta_valid;
    logic [127:0] o_meta;
    logic         o_frame_err;
`ifdef MAC_META_STATS_EN
    logic [31:0]  o_pkt_cnt;
    logic [15:0]  o_err_cnt;

    modport slave (
        input  i_pkt_valid, i_pkt,
        output o_pkt_valid, o_pkt, o_meta_valid, o_meta, o_frame_err, o_pkt_cnt, o_err_cnt
    );
    modport master (
        output i_pkt_valid, i_pkt,
        input  o_pkt_valid, o_pkt, o_meta_valid, o_meta, o_frame_err, o_pkt_cnt, o_err_cnt
    );
`else
    modport slave (
        input  i_pkt_valid, i_pkt,
        output o_pkt_valid, o_pkt, o_meta_valid, o_meta, o_frame_err
    );
    modport master (
        output i_pkt_valid, i_pkt,
        input  o_pkt_valid, o_pkt, o_meta_valid, o_meta, o_frame_err
    );
`endif
endinterface

// File: rtl/mac_meta_gen.sv
// Parses packet heads into rewrite metadata and forwards the bus one cycle late.
// Optional MAC_META_STATS_EN adds accepted-packet and framing-error counters.
//
// state  | meaning
// IDLE   | between packets, expecting head or single
// IN_PKT | inside a multi-beat packet, expecting body or tail
module mac_meta_gen (
    input  logic          i_clk,
    input  logic          i_rst,
    mac_meta_gen_if.slave bus
);
    typedef enum logic {IDLE, IN_PKT} state_t;

    localparam logic [1:0] BEAT_BODY   = 2'b00;
    localparam logic [1:0] BEAT_HEAD   = 2'b01;
    localparam logic [1:0] BEAT_TAIL   = 2'b10;
    localparam logic [1:0] BEAT_SINGLE = 2'b11;

    state_t       state, state_next;
    logic         gen_meta, frame_err_evt;
    logic [1:0]   beat_type;
    logic [47:0]  dst_mac, src_mac;
    logic [15:0]  ethertype;
    logic [127:0] meta_next;
    logic [7:0]   seq;

    logic         pkt_valid_q, meta_valid_q, frame_err_q;
    logic [133:0] pkt_q;
    logic [127:0] meta_q;

    assign beat_type = bus.i_pkt[133:132];
    assign dst_mac   = bus.i_pkt[127:80];
    assign src_mac   = bus.i_pkt[79:32];
    assign ethertype = bus.i_pkt[31:16];

    // Addresses are swapped so the rewrite stage can drop them straight into the reply header.
    assign meta_next = {src_mac, dst_mac, ethertype, 5'b0,
                        (ethertype == 16'h8100),
                        (dst_mac == 48'hFFFF_FFFF_FFFF),
                        dst_mac[40], seq};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        gen_meta      = 1'b0;
        frame_err_evt = 1'b0;
        if (bus.i_pkt_valid) begin
            case (state)
                IDLE: begin
                    case (beat_type)
                        BEAT_HEAD: begin
                            gen_meta   = 1'b1;
                            state_next = IN_PKT;
                        end
                        BEAT_SINGLE: gen_meta = 1'b1;
                        default:     frame_err_evt = 1'b1;
                    endcase
                end
                IN_PKT: begin
                    case (beat_type)
                        BEAT_BODY: state_next = IN_PKT;
                        BEAT_TAIL: state_next = IDLE;
                        BEAT_HEAD: begin
                            frame_err_evt = 1'b1;
                            gen_meta      = 1'b1;
                        end
                        default: begin
                            frame_err_evt = 1'b1;
                            gen_meta      = 1'b1;
                            state_next    = IDLE;
                        end
                    endcase
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pkt_valid_q  <= 1'b0;
            pkt_q        <= '0;
            meta_valid_q <= 1'b0;
            meta_q       <= '0;
            frame_err_q  <= 1'b0;
            seq          <= '0;
        end else begin
            pkt_valid_q  <= bus.i_pkt_valid;
            pkt_q        <= bus.i_pkt;
            meta_valid_q <= gen_meta;
            if (gen_meta) begin
                meta_q <= meta_next;
                seq    <= seq + 8'd1;
            end
            if (frame_err_evt) frame_err_q <= 1'b1;
        end
    end

    assign bus.o_pkt_valid  = pkt_valid_q;
    assign bus.o_pkt        = pkt_q;
    assign bus.o_meta_valid = meta_valid_q;
    assign bus.o_meta       = meta_q;
    assign bus.o_frame_err  = frame_err_q;

`ifdef MAC_META_STATS_EN
    logic [31:0] pkt_cnt;
    logic [15:0] err_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (gen_meta) pkt_cnt <= pkt_cnt + 32'd1;
            if (frame_err_evt && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
        end
    end

    assign bus.o_pkt_cnt = pkt_cnt;
    assign bus.o_err_cnt = err_cnt;
`endif
endmodule

// File: tb/tb_mac_meta_gen.sv
// Directed bench for mac_meta_gen: table of beats with hand-computed outputs plus
// sequences for seq-number wrap and reset mid-packet.
module tb_mac_meta_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mac_meta_gen_if bus ();

    mac_meta_gen dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [1:0]   typ;
        logic [127:0] data;
        logic         exp_mv;
        logic [127:0] exp_meta;
        logic         exp_ferr;
        logic [31:0]  exp_pc;
        logic [15:0]  exp_ec;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_data(input logic [47:0] dst, input logic [47:0] src,
                                             input logic [15:0] eth);
        return {dst, src, eth, 16'h5A5A};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.i_pkt_valid = 1'b0;
        bus.i_pkt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [1:0] typ, input logic [3:0] inv,
                         input logic [127:0] data);
        @(negedge clk);
        bus.i_pkt_valid = v;
        bus.i_pkt = {typ, inv, data};
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] M0 = {48'hAABBCCDDEEFF, 48'h112233445566, 16'h0800, 5'b0, 3'b001, 8'd0};
    localparam logic [127:0] M1 = {48'h020000000001, 48'hFFFFFFFFFFFF, 16'h8100, 5'b0, 3'b111, 8'd1};
    localparam logic [127:0] M2 = {48'h66778899AABB, 48'h001122334455, 16'h8100, 5'b0, 3'b100, 8'd2};
    localparam logic [127:0] M3 = {48'h0A0B0C0D0E0F, 48'h0100005E0001, 16'h0800, 5'b0, 3'b001, 8'd3};
    localparam logic [127:0] M4 = {48'h123456789ABC, 48'hFFFFFFFFFFFF, 16'h8100, 5'b0, 3'b111, 8'd4};

    initial begin
        logic [127:0] body_d;
        logic [127:0] exp_meta;
        body_d = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

        //          v     typ    data                                                    mv    meta ferr pc     ec
        vecs[0] = '{1'b1, 2'b01, mk_data(48'h112233445566, 48'hAABBCCDDEEFF, 16'h0800), 1'b1, M0, 1'b0, 32'd1, 16'd0};
        vecs[1] = '{1'b1, 2'b00, body_d,                                                1'b0, M0, 1'b0, 32'd1, 16'd0};
        vecs[2] = '{1'b0, 2'b01, body_d,                                                1'b0, M0, 1'b0, 32'd1, 16'd0};
        vecs[3] = '{1'b1, 2'b10, ~body_d,                                               1'b0, M0, 1'b0, 32'd1, 16'd0};
        vecs[4] = '{1'b1, 2'b11, mk_data(48'hFFFFFFFFFFFF, 48'h020000000001, 16'h8100), 1'b1, M1, 1'b0, 32'd2, 16'd0};
        vecs[5] = '{1'b1, 2'b00, body_d,                                                1'b0, M1, 1'b1, 32'd2, 16'd1};
        vecs[6] = '{1'b1, 2'b01, mk_data(48'h001122334455, 48'h66778899AABB, 16'h8100), 1'b1, M2, 1'b1, 32'd3, 16'd1};
        vecs[7] = '{1'b1, 2'b01, mk_data(48'h0100005E0001, 48'h0A0B0C0D0E0F, 16'h0800), 1'b1, M3, 1'b1, 32'd4, 16'd2};
        vecs[8] = '{1'b1, 2'b11, mk_data(48'hFFFFFFFFFFFF, 48'h123456789ABC, 16'h8100), 1'b1, M4, 1'b1, 32'd5, 16'd3};
        vecs[9] = '{1'b1, 2'b10, body_d,                                                1'b0, M4, 1'b1, 32'd5, 16'd4};

        do_reset();
        #1;
        chk("rst_pkt_valid", bus.o_pkt_valid, 1'b0);
        chk("rst_pkt", bus.o_pkt, '0);
        chk("rst_meta_valid", bus.o_meta_valid, 1'b0);
        chk("rst_meta", bus.o_meta, '0);
        chk("rst_frame_err", bus.o_frame_err, 1'b0);
`ifdef MAC_META_STATS_EN
        chk("rst_pkt_cnt", bus.o_pkt_cnt, '0);
        chk("rst_err_cnt", bus.o_err_cnt, '0);
`endif

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v, vecs[i].typ, 4'(i), vecs[i].data);
            chk($sformatf("vec%0d_pkt_valid", i), bus.o_pkt_valid, vecs[i].v);
            chk($sformatf("vec%0d_pkt", i), bus.o_pkt, {vecs[i].typ, 4'(i), vecs[i].data});
            chk($sformatf("vec%0d_meta_valid", i), bus.o_meta_valid, vecs[i].exp_mv);
            chk($sformatf("vec%0d_meta", i), bus.o_meta, vecs[i].exp_meta);
            chk($sformatf("vec%0d_frame_err", i), bus.o_frame_err, vecs[i].exp_ferr);
`ifdef MAC_META_STATS_EN
            chk($sformatf("vec%0d_pkt_cnt", i), bus.o_pkt_cnt, vecs[i].exp_pc);
            chk($sformatf("vec%0d_err_cnt", i), bus.o_err_cnt, vecs[i].exp_ec);
`endif
        end

        // 257 back-to-back singles: sequence wraps 255 -> 0, one pulse per cycle.
        do_reset();
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, 2'b11, 4'h0, mk_data(48'h000000000002, 48'h00000000ABCD, 16'h0800));
            exp_meta = {48'h00000000ABCD, 48'h000000000002, 16'h0800, 5'b0, 3'b000, 8'(i)};
            chk($sformatf("wrap%0d_meta_valid", i), bus.o_meta_valid, 1'b1);
            chk($sformatf("wrap%0d_meta", i), bus.o_meta, exp_meta);
        end
        drive(1'b0, 2'b11, 4'h0, '0);
        chk("wrap_idle_meta_valid", bus.o_meta_valid, 1'b0);
        chk("wrap_idle_meta_seq", bus.o_meta[7:0], 8'd0);
        chk("wrap_frame_err", bus.o_frame_err, 1'b0);
`ifdef MAC_META_STATS_EN
        chk("wrap_pkt_cnt", bus.o_pkt_cnt, 32'd257);
`endif

        // Reset in the middle of a packet, then a stray tail.
        do_reset();
        drive(1'b1, 2'b01, 4'h0, mk_data(48'h001122334455, 48'h66778899AABB, 16'h0800));
        drive(1'b1, 2'b00, 4'h5, body_d);
        chk("mid_pkt_valid_pre", bus.o_pkt_valid, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_pkt_valid", bus.o_pkt_valid, 1'b0);
        chk("mid_rst_pkt", bus.o_pkt, '0);
        chk("mid_rst_meta_valid", bus.o_meta_valid, 1'b0);
        chk("mid_rst_meta", bus.o_meta, '0);
        chk("mid_rst_frame_err", bus.o_frame_err, 1'b0);
`ifdef MAC_META_STATS_EN
        chk("mid_rst_pkt_cnt", bus.o_pkt_cnt, '0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 2'b10, 4'h2, ~body_d);
        chk("post_rst_tail_err", bus.o_frame_err, 1'b1);
        chk("post_rst_tail_mv", bus.o_meta_valid, 1'b0);
        chk("post_rst_tail_pkt", bus.o_pkt, {2'b10, 4'h2, ~body_d});
`ifdef MAC_META_STATS_EN
        chk("post_rst_err_cnt", bus.o_err_cnt, 16'd1);
`endif
        drive(1'b1, 2'b01, 4'h0, mk_data(48'h001122334455, 48'h66778899AABB, 16'h0800));
        chk("post_rst_head_mv", bus.o_meta_valid, 1'b1);
        chk("post_rst_head_meta", bus.o_meta,
            {48'h66778899AABB, 48'h001122334455, 16'h0800, 5'b0, 3'b000, 8'd0});
        drive(1'b0, 2'b00, 4'h0, '0);
        chk("post_rst_idle_mv", bus.o_meta_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
